uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two requesters: requester 0 is the processor's send path (control-register send bit plus data register); requester 1 is the light-sensor auto-report path.
- Round-robin grant, byte multiplexing, tx_start generation and completion detection via tx_rdy.
- A watchdog aborts a transfer whose tx_rdy never arrives.
- Sits between the UART control/data register logic and the transmitter.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 32 +++
 rtl/arb_timeout_cnt.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_TX = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Requester indices into req/gnt/done
  localparam int REQ_CPU    = 0;
  localparam int REQ_SENSOR = 1;

  // Default watchdog window and matching counter width (2^21 > 2_000_000)
  localparam int DEF_TIMEOUT_CYC = 2000000;
  localparam int DEF_CNT_W       = 21;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle for the UART transmit arbiter.
// Latency: n/a (wires only).
// Backpressure: req is a level held until done; tx_rdy marks frame completion.
// Ports: req/data0/data1/tx_rdy/clr_err into the arbiter;
//        tx_start/tx_data/gnt/done/busy/timeout_err out of the arbiter.
interface uart_tx_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        req;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic              tx_rdy;
  logic              clr_err;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              busy;
  logic              timeout_err;

  // Driving side: requesters plus the transmitter's completion pulse
  modport master (
    output req, data0, data1, tx_rdy, clr_err,
    input  tx_start, tx_data, gnt, done, busy, timeout_err
  );

  // Arbiter side
  modport slave (
    input  req, data0, data1, tx_rdy, clr_err,
    output tx_start, tx_data, gnt, done, busy, timeout_err
  );
endinterface

// File: rtl/arb_timeout_cnt.sv
// Watchdog counter: tc is high while the count equals TIMEOUT_CYC-1.
// Latency: clr/en take effect on the next clock; tc is decoded from the register.
// Backpressure: none; en simply holds the count when low.
// Ports: clk, rst (async active-low), clr (sync clear, wins over en), en, tc.
module arb_timeout_cnt #(
  parameter int CNT_W       = 21,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter between the CPU send path and the sensor report path.
// Latency: req in IDLE -> gnt/tx_start next cycle; tx_rdy -> done next cycle, IDLE the cycle after.
// Backpressure: requesters hold req and data until done; a missing tx_rdy is aborted by the watchdog.
// Ports: clk, rst (async active-low), bus (slave side of uart_tx_arbiter_if).
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  arb_state_t        state, state_nxt;
  logic              last;        // last-served requester index
  logic              win;         // winner index when leaving IDLE
  logic              load;        // capture grant/data/pointer
  logic              cnt_clr, cnt_en, tc;
  logic              err_set;
  logic              tx_start_c, busy_c;
  logic [1:0]        gnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              timeout_err_q;

  // Contention goes to whichever requester was not served last
  assign win = (bus.req == 2'b11) ? ~last : bus.req[REQ_SENSOR];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tx_start_c = 1'b0;
    busy_c     = 1'b1;
    load       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (|bus.req) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        tx_start_c = 1'b1;
        cnt_clr    = 1'b1;
        state_nxt  = WAIT_TX;
      end
      WAIT_TX: begin
        cnt_en = 1'b1;
        // tx_rdy takes priority over a simultaneous terminal count
        if (bus.tx_rdy) begin
          state_nxt = DONE;
        end else if (tc) begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q     <= 2'b00;
      tx_data_q <= '0;
      last      <= 1'b1;
    end else if (load) begin
      gnt_q[REQ_CPU]    <= ~win;
      gnt_q[REQ_SENSOR] <= win;
      tx_data_q         <= win ? bus.data1 : bus.data0;
      last              <= win;
    end else if (state == DONE) begin
      gnt_q <= 2'b00;
    end
  end

  // Sticky abort flag; a new abort beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err_q <= 1'b0;
    end else if (err_set) begin
      timeout_err_q <= 1'b1;
    end else if (bus.clr_err) begin
      timeout_err_q <= 1'b0;
    end
  end

  arb_timeout_cnt #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  // All outputs decode from registers only
  assign bus.tx_start    = tx_start_c;
  assign bus.busy        = busy_c;
  assign bus.tx_data     = tx_data_q;
  assign bus.gnt         = gnt_q;
  assign bus.done        = (state == DONE) ? gnt_q : 2'b00;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: driver pushes expected grants, monitor checks them.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;

  localparam int DW = 8;
  localparam int TO = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] dat;
    logic       te;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [1:0] pending;
  logic [7:0] md0, md1;
  int         last_srv = 1;
  bit         sticky   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
    end
  endtask

  // Monitor: checks grant/data at tx_start and the completion at done
  always @(negedge clk) begin
    if (rst) begin
      if (bus.tx_start) begin
        chk("exp_pending_at_start", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("start_gnt",  bus.gnt,     exp_q[0].gnt);
          chk("start_data", bus.tx_data, exp_q[0].dat);
          chk("start_busy", bus.busy,    1);
        end
      end
      if (bus.done != 2'b00) begin
        chk("exp_pending_at_done", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("done_vec",    bus.done,        mon_e.gnt);
          chk("done_gnt",    bus.gnt,         mon_e.gnt);
          chk("done_data",   bus.tx_data,     mon_e.dat);
          chk("done_terr",   bus.timeout_err, mon_e.te);
        end
      end
    end
  end

  // One transfer: j is the WAIT_TX cycle (0-based) carrying tx_rdy; j >= TO means none.
  task automatic do_xfer(input logic [1:0] newreq, input logic [7:0] nd0, input logic [7:0] nd1,
                         input int j, input bit drop_mid, input bit clr_first, input bit clr_at_abort);
    int   w, lat, exp_lat;
    bit   te_before;
    exp_t e;
    if (newreq[0] && !pending[0]) begin md0 = nd0; bus.data0 = nd0; end
    if (newreq[1] && !pending[1]) begin md1 = nd1; bus.data1 = nd1; end
    pending = pending | newreq;
    if (pending == 2'b00) begin
      pending = 2'b01; md0 = nd0; bus.data0 = nd0;
    end
    bus.req     = pending;
    bus.clr_err = clr_first;
    if (clr_first) sticky = 1'b0;
    te_before = sticky;
    if (pending == 2'b11) w = (last_srv == 0) ? 1 : 0;
    else                  w = pending[1] ? 1 : 0;
    last_srv = w;
    if (j >= TO) sticky = 1'b1;
    e.gnt = (w == 1) ? 2'b10 : 2'b01;
    e.dat = (w == 1) ? md1 : md0;
    e.te  = sticky;
    exp_q.push_back(e);

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus.clr_err = 1'b0;
    end while (!bus.tx_start && lat < 5);
    chk("start_latency", lat, 1);
    chk("err_at_start", bus.timeout_err, te_before);

    exp_lat = (j < TO) ? j + 2 : TO + 1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      bus.tx_rdy  = 1'b0;
      bus.clr_err = 1'b0;
      if (bus.done != 2'b00 || lat > 40) break;
      if (lat == 1) begin
        if (drop_mid) begin
          pending[w] = 1'b0;
          bus.req    = pending;
        end
        if (w == 1) bus.data1 = 8'($urandom);
        else        bus.data0 = 8'($urandom);
      end
      if (lat - 1 == j) bus.tx_rdy = 1'b1;
      if (clr_at_abort && lat - 1 == TO - 1) bus.clr_err = 1'b1;
    end
    chk("done_latency", lat, exp_lat);
    pending[w] = 1'b0;
    bus.req    = pending;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_gnt",  bus.gnt,  0);
  endtask

  initial begin
    logic [1:0] nr;
    int         jj;
    exp_t       e0;
    bus.req     = 2'b00;
    bus.data0   = '0;
    bus.data1   = '0;
    bus.tx_rdy  = 1'b0;
    bus.clr_err = 1'b0;
    pending     = 2'b00;
    md0         = '0;
    md1         = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", bus.tx_start,    0);
    chk("rst_tx_data",  bus.tx_data,     0);
    chk("rst_gnt",      bus.gnt,         0);
    chk("rst_done",     bus.done,        0);
    chk("rst_busy",     bus.busy,        0);
    chk("rst_terr",     bus.timeout_err, 0);
    rst = 1'b1;

    // Single request
    do_xfer(2'b01, 8'h5A, 8'h00, 9, 0, 0, 0);
    // Contention and alternation
    do_xfer(2'b11, 8'h11, 8'h22, 3, 0, 0, 0);
    do_xfer(2'b00, 8'h00, 8'h00, 2, 0, 0, 0);
    do_xfer(2'b11, 8'h11, 8'h22, 4, 0, 0, 0);
    do_xfer(2'b00, 8'h00, 8'h00, 1, 0, 0, 0);
    // Timeout, then clear
    do_xfer(2'b01, 8'hA5, 8'h00, 20, 0, 0, 0);
    do_xfer(2'b10, 8'h00, 8'hC3, 2, 0, 1, 0);
    // tx_rdy on the terminal-count cycle
    do_xfer(2'b10, 8'h00, 8'h96, TO - 1, 0, 0, 0);
    // Request dropped mid-transfer
    do_xfer(2'b01, 8'h3E, 8'h00, 5, 1, 0, 0);

    // Stray tx_rdy while idle
    bus.tx_rdy = 1'b1;
    @(negedge clk);
    bus.tx_rdy = 1'b0;
    chk("stray_tx_start", bus.tx_start, 0);
    chk("stray_gnt",      bus.gnt,      0);
    chk("stray_done",     bus.done,     0);
    chk("stray_busy",     bus.busy,     0);
    @(negedge clk);

    // Clear on the abort cycle loses to the new abort
    do_xfer(2'b01, 8'h5C, 8'h00, 30, 0, 0, 1);

    // Reset in the middle of a transfer
    md0 = 8'h77; bus.data0 = md0; pending = 2'b01; bus.req = pending;
    e0.gnt = 2'b01; e0.dat = md0; e0.te = sticky;
    exp_q.push_back(e0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tx_start", bus.tx_start,    0);
    chk("mid_rst_tx_data",  bus.tx_data,     0);
    chk("mid_rst_gnt",      bus.gnt,         0);
    chk("mid_rst_done",     bus.done,        0);
    chk("mid_rst_busy",     bus.busy,        0);
    chk("mid_rst_terr",     bus.timeout_err, 0);
    exp_q.delete();
    last_srv = 1; sticky = 1'b0;
    pending = 2'b10; md1 = 8'h3C; bus.data1 = md1; bus.req = pending;
    @(negedge clk);
    rst = 1'b1;
    do_xfer(2'b00, 8'h00, 8'h00, 3, 0, 0, 0);
    do_xfer(2'b11, 8'h44, 8'h88, 2, 0, 0, 0);
    do_xfer(2'b00, 8'h00, 8'h00, 2, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      nr = 2'($urandom_range(0, 3));
      jj = $urandom_range(0, 19);
      do_xfer(nr, 8'($urandom), 8'($urandom), jj,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
